down_timer_arbiter: RTL and testbench

- Shares a single programmable down counter among NREQ requesters.
- Arbitrates round-robin, loads the winner's start value, and counts down to zero under a count-enable.
- Pulses a per-requester done when the count completes.
- Sits between the timing clients and the shared down-count datapath, so the design needs only one counter instance.

---
 rtl/down_timer_arbiter_if.sv | 34 +++
 rtl/down_timer_arbiter.sv | 178 +++++++++++++++++
 tb/tb_down_timer_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/down_timer_arbiter_if.sv
// Bundle of request/grant and counter signals shared between the timing
// clients (master side) and the shared down-timer arbiter (slave side).
interface down_timer_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] load_val;
    logic                  enable;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      cnt;
    logic [NREQ-1:0]       done;

    modport master (
        output req,
        output load_val,
        output enable,
        input  gnt,
        input  busy,
        input  cnt,
        input  done
    );

    modport slave (
        input  req,
        input  load_val,
        input  enable,
        output gnt,
        output busy,
        output cnt,
        output done
    );
endinterface

// File: rtl/down_timer_arbiter.sv
// Shared programmable down counter with a round-robin front end.
// One requester at a time owns the counter: its start value is loaded on
// grant, the counter decrements on enabled cycles, and a one-cycle done
// pulse is returned to the owner when an enabled cycle finds the count at
// zero. Dropping req while owning the counter abandons it without done.
module down_timer_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    down_timer_arbiter_if.slave  bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NREQ-1:0]  REQ_ZERO = {NREQ{1'b0}};
    localparam logic [PW-1:0]    PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]    PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    PTR_LAST = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic              busy_q,  busy_d;
    logic [WIDTH-1:0]  cnt_q,   cnt_d;
    logic [NREQ-1:0]   done_q,  done_d;
    logic [PW-1:0]     ptr_q,   ptr_d;

    logic [PW-1:0]     winner_s;
    logic [WIDTH-1:0]  winner_load_s;
    logic              owner_req_s;

    // First set request at or above the pointer, otherwise the first set
    // request below it (wrap-around search). Returns the pointer when no
    // request is set; callers only use the result when req is nonzero.
    function automatic logic [PW-1:0] rr_pick(
        input logic [NREQ-1:0] r,
        input logic [PW-1:0]   p
    );
        logic [PW-1:0] w;
        logic          found;
        w     = p;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && r[i] && (i >= int'(p))) begin
                w     = PW'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && r[i]) begin
                w     = PW'(i);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Pointer to the slot just past the winner, wrapping at NREQ-1.
    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] w);
        logic [PW-1:0] n;
        if (w == PTR_LAST) begin
            n = PTR_ZERO;
        end else begin
            n = w + PTR_ONE;
        end
        return n;
    endfunction

    // One-hot vector with only bit w set.
    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] w);
        logic [NREQ-1:0] v;
        v = REQ_ZERO;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = (PW'(i) == w);
        end
        return v;
    endfunction

    // Winner selection and its start value, looked up with constant slices.
    always_comb begin
        winner_s      = rr_pick(bus.req, ptr_q);
        winner_load_s = CNT_ZERO;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == winner_s) begin
                winner_load_s = bus.load_val[i*WIDTH +: WIDTH];
            end
        end
        owner_req_s = |(bus.req & gnt_q);
    end

    // Next-state and next-output logic of the IDLE/COUNT/RELEASE machine.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        done_d  = REQ_ZERO;
        ptr_d   = ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    gnt_d   = onehot(winner_s);
                    cnt_d   = winner_load_s;
                    busy_d  = 1'b1;
                    ptr_d   = ptr_after(winner_s);
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_COUNT: begin
                // Abandon wins over completion so a dropped request never
                // sees a done pulse.
                if (!owner_req_s) begin
                    gnt_d   = REQ_ZERO;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (bus.enable && (cnt_q == CNT_ZERO)) begin
                    done_d  = gnt_q;
                    gnt_d   = REQ_ZERO;
                    busy_d  = 1'b0;
                    state_d = ST_RELEASE;
                end else if (bus.enable) begin
                    cnt_d   = cnt_q - CNT_ONE;
                end else begin
                    cnt_d   = cnt_q;
                end
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
            end

            default: begin
                gnt_d   = REQ_ZERO;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any count without done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= REQ_ZERO;
            busy_q  <= 1'b0;
            cnt_q   <= CNT_ONES;
            done_q  <= REQ_ZERO;
            ptr_q   <= PTR_ZERO;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.busy = busy_q;
    assign bus.cnt  = cnt_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_down_timer_arbiter.sv
// Directed bench for down_timer_arbiter. Stimulus pushes expected grant and
// done events into a queue; a monitor pops and compares them whenever the
// DUT shows a new grant or a done pulse.
module tb_down_timer_arbiter;

    logic clk;
    logic rst;

    down_timer_arbiter_if #(.NREQ(4), .WIDTH(3)) bus ();

    down_timer_arbiter #(.NREQ(4), .WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_done;
        logic [3:0] vec;
        logic [2:0] c;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh(input int k);
        logic [3:0] v;
        v = 4'b0001;
        return v << k;
    endfunction

    task automatic set_load(input int k, input int v);
        bus.load_val[k*3 +: 3] = 3'(v);
    endtask

    task automatic push_gnt(input int k, input int l);
        ev_t e;
        e.is_done = 1'b0;
        e.vec     = oh(k);
        e.c       = 3'(l);
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int k);
        ev_t e;
        e.is_done = 1'b1;
        e.vec     = oh(k);
        e.c       = 3'd0;
        exp_q.push_back(e);
    endtask

    // Called just after the grant edge with enable high: walks the count
    // down to zero, checks the done pulse, drops req[k] during it, and
    // returns one cycle later in IDLE.
    task automatic count_out(input int k, input int l);
        push_done(k);
        for (int v = l; v >= 0; v--) begin
            chk("cnt_seq", int'(bus.cnt), v);
            chk("gnt_hold", int'(bus.gnt), int'(oh(k)));
            tick();
        end
        chk("done_pulse", int'(bus.done), int'(oh(k)));
        chk("busy_at_done", int'(bus.busy), 0);
        bus.req[k] = 1'b0;
        tick();
        chk("done_one_cycle", int'(bus.done), 0);
    endtask

    // Monitor: compares every new grant and every done pulse against the
    // head of the expectation queue.
    initial begin
        logic [3:0] prev;
        ev_t        e;
        prev = 4'b0000;
        forever begin
            @(negedge clk);
            if (bus.done != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", int'(bus.done), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_is_done", int'(bus.done != 4'b0000), int'(e.is_done));
                    chk("done_vec", int'(bus.done), int'(e.vec));
                    chk("done_gnt_zero", int'(bus.gnt), 0);
                    chk("done_busy_zero", int'(bus.busy), 0);
                end
            end
            if ((bus.gnt != 4'b0000) && (bus.gnt != prev)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_gnt", int'(bus.gnt), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_is_gnt", int'(!e.is_done), 1);
                    chk("gnt_vec", int'(bus.gnt), int'(e.vec));
                    chk("gnt_load", int'(bus.cnt), int'(e.c));
                    chk("gnt_busy", int'(bus.busy), 1);
                end
            end
            prev = bus.gnt;
        end
    end

    // Directed stimulus sequence.
    initial begin
        rst          = 1'b0;
        bus.req      = 4'b0000;
        bus.load_val = 12'h000;
        bus.enable   = 1'b0;
        tick();
        tick();
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_cnt", int'(bus.cnt), 7);
        chk("rst_done", int'(bus.done), 0);
        rst = 1'b1;
        tick();

        // Round-robin: all request, load 1, each re-raises after its done.
        for (int k = 0; k < 4; k++) set_load(k, 1);
        bus.enable = 1'b1;
        bus.req    = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            push_gnt(i % 4, 1);
            tick();
            count_out(i % 4, 1);
            bus.req[i % 4] = 1'b1;
        end
        bus.req = 4'b0000;
        tick();

        // Single requester, load 5; stays idle after req drops.
        set_load(1, 5);
        bus.req = 4'b0010;
        push_gnt(1, 5);
        tick();
        count_out(1, 5);
        tick();
        chk("idle_gnt", int'(bus.gnt), 0);
        chk("idle_busy", int'(bus.busy), 0);

        // Enable gating: owner 0, load 3, enable 0,1,0,1...
        set_load(0, 3);
        bus.req = 4'b0001;
        push_gnt(0, 3);
        tick();
        push_done(0);
        for (int c = 0; c < 8; c++) begin
            bus.enable = (c % 2 == 1);
            chk("gated_cnt", int'(bus.cnt), 3 - c / 2);
            tick();
        end
        chk("gated_done", int'(bus.done), 1);
        bus.req    = 4'b0000;
        bus.enable = 1'b1;
        tick();

        // Abandon: owner 1, load 7, drop at cnt=3 with 0 and 2 pending.
        set_load(1, 7);
        set_load(2, 4);
        set_load(0, 0);
        bus.req = 4'b0111;
        push_gnt(1, 7);
        tick();
        for (int v = 7; v > 3; v--) begin
            chk("abandon_cnt", int'(bus.cnt), v);
            tick();
        end
        chk("abandon_at3", int'(bus.cnt), 3);
        bus.req = 4'b0101;
        tick();
        chk("abandon_gnt", int'(bus.gnt), 0);
        chk("abandon_busy", int'(bus.busy), 0);
        chk("abandon_done", int'(bus.done), 0);
        chk("abandon_cnt_hold", int'(bus.cnt), 3);
        push_gnt(2, 4);
        tick();
        count_out(2, 4);
        // Requester 0 still pending with load 0: done after one cycle.
        push_gnt(0, 0);
        tick();
        count_out(0, 0);

        // Maximum load value.
        set_load(3, 7);
        bus.req = 4'b1000;
        push_gnt(3, 7);
        tick();
        count_out(3, 7);

        // Abandon exactly when completion would fire.
        set_load(2, 0);
        bus.req = 4'b0100;
        push_gnt(2, 0);
        tick();
        chk("ab0_cnt", int'(bus.cnt), 0);
        bus.req = 4'b0000;
        tick();
        chk("ab0_gnt", int'(bus.gnt), 0);
        chk("ab0_busy", int'(bus.busy), 0);
        chk("ab0_done", int'(bus.done), 0);
        tick();
        chk("ab0_done_later", int'(bus.done), 0);

        // Asynchronous reset mid-count: owner 2 at cnt=4.
        set_load(2, 6);
        bus.req = 4'b0100;
        push_gnt(2, 6);
        tick();
        tick();
        tick();
        chk("pre_rst_cnt", int'(bus.cnt), 4);
        chk("pre_rst_gnt", int'(bus.gnt), 4);
        #2;
        rst     = 1'b0;
        bus.req = 4'b0000;
        #1;
        chk("arst_gnt", int'(bus.gnt), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_cnt", int'(bus.cnt), 7);
        chk("arst_done", int'(bus.done), 0);
        tick();
        rst = 1'b1;
        set_load(0, 2);
        bus.req = 4'b0001;
        push_gnt(0, 2);
        tick();
        chk("post_rst_gnt", int'(bus.gnt), 1);
        count_out(0, 2);

        tick();
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
